// File: rtl/branch_rs_pkg.sv
// Shared types for the reservation stations: branch function encoding,
// the branch entry record and the CDB operand-capture test.
package branch_rs_pkg;

    typedef enum logic [2:0] {
        BR_EQ  = 3'd0,
        BR_NEQ = 3'd1,
        BR_LT  = 3'd2,
        BR_LTU = 3'd3,
        BR_GE  = 3'd4,
        BR_GEU = 3'd5,
        BR_DBR = 3'd6
    } br_func_t;

    // Tags are stored at a fixed width so the record can be shared between
    // stations; a station's ROB tag (ROB_IX+1 bits) must not exceed this.
    localparam int MAX_TAG_W = 8;

    typedef struct packed {
        logic                 valid;
        br_func_t             func;
        logic [31:0]          v1;
        logic [31:0]          v2;
        logic                 rdy1;
        logic                 rdy2;
        logic [MAX_TAG_W-1:0] q1;
        logic [MAX_TAG_W-1:0] q2;
        logic [31:0]          pc;
        logic [31:0]          imm;
        logic [MAX_TAG_W-1:0] tag;
    } br_rs_entry_t;

    function automatic logic operand_hit(
        input logic                 rdy,
        input logic [MAX_TAG_W-1:0] q,
        input logic                 cdb_valid,
        input logic [MAX_TAG_W-1:0] cdb_tag
    );
        return !rdy && cdb_valid && (q == cdb_tag);
    endfunction

endpackage

// File: rtl/branch_rs_select.sv
// Priority encoder over the station's ready vector; index 0 is the oldest
// entry, so the lowest set bit wins.
module rs_oldest_ready_select #(
    parameter int NUM_ENTRIES = 4
) (
    input  logic [NUM_ENTRIES-1:0]         ready,
    output logic [$clog2(NUM_ENTRIES)-1:0] index,
    output logic                           found
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);

    always_comb begin
        index = '0;
        found = 1'b0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (ready[i]) begin
                index = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/branch_rs.sv
// Branch reservation station: collapsing queue of branch micro-ops with CDB
// wakeup, issuing the oldest ready op through a registered valid/ready stage.
module branch_rs
    import branch_rs_pkg::*;
#(
    parameter int NUM_ENTRIES = 4,
    parameter int ROB_IX      = 2
) (
    input  logic                               clk_in,
    input  logic                               rst_in,
    input  logic                               flush_in,

    input  logic                               disp_valid_in,
    output logic                               disp_ready_out,
    input  logic [2:0]                         disp_func_in,
    input  logic [31:0]                        disp_v1_in,
    input  logic [31:0]                        disp_v2_in,
    input  logic                               disp_rdy1_in,
    input  logic                               disp_rdy2_in,
    input  logic [ROB_IX:0]                    disp_q1_in,
    input  logic [ROB_IX:0]                    disp_q2_in,
    input  logic [31:0]                        disp_pc_in,
    input  logic [31:0]                        disp_imm_in,
    input  logic [ROB_IX:0]                    disp_tag_in,

    input  logic                               cdb_valid_in,
    input  logic [ROB_IX:0]                    cdb_tag_in,
    input  logic [31:0]                        cdb_value_in,

    output logic                               iss_valid_out,
    input  logic                               iss_ready_in,
    output logic [2:0]                         iss_func_out,
    output logic [31:0]                        iss_rval1_out,
    output logic [31:0]                        iss_rval2_out,
    output logic [31:0]                        iss_pc_out,
    output logic [31:0]                        iss_imm_out,
    output logic [ROB_IX:0]                    iss_tag_out,

    output logic [$clog2(NUM_ENTRIES+1)-1:0]   count_out
);

    localparam int TAG_W = ROB_IX + 1;
    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int CNT_W = $clog2(NUM_ENTRIES + 1);

    br_rs_entry_t         ent_q [NUM_ENTRIES];
    br_rs_entry_t         woken [NUM_ENTRIES];
    br_rs_entry_t         ent_d [NUM_ENTRIES];
    br_rs_entry_t         new_ent;

    logic [CNT_W-1:0]     count_q;
    logic [CNT_W-1:0]     count_after;
    logic [CNT_W-1:0]     count_d;

    logic [NUM_ENTRIES-1:0] ready_vec;
    logic [IDX_W-1:0]     sel_idx;
    logic                 sel_found;
    logic                 out_load;
    logic                 disp_fire;
    logic [MAX_TAG_W-1:0] cdb_tag_w;
    logic [MAX_TAG_W-1:0] disp_q1_w;
    logic [MAX_TAG_W-1:0] disp_q2_w;

    logic                 iss_valid_q;
    logic [2:0]           iss_func_q;
    logic [31:0]          iss_rval1_q;
    logic [31:0]          iss_rval2_q;
    logic [31:0]          iss_pc_q;
    logic [31:0]          iss_imm_q;
    logic [TAG_W-1:0]     iss_tag_q;

    assign cdb_tag_w = MAX_TAG_W'(cdb_tag_in);
    assign disp_q1_w = MAX_TAG_W'(disp_q1_in);
    assign disp_q2_w = MAX_TAG_W'(disp_q2_in);

    // Readiness uses registered flags only, so a CDB wakeup this cycle
    // becomes eligible for issue on the following cycle.
    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            woken[i]     = ent_q[i];
            ready_vec[i] = ent_q[i].valid && ent_q[i].rdy1 && ent_q[i].rdy2;
            if (ent_q[i].valid && operand_hit(ent_q[i].rdy1, ent_q[i].q1, cdb_valid_in, cdb_tag_w)) begin
                woken[i].v1   = cdb_value_in;
                woken[i].rdy1 = 1'b1;
            end
            if (ent_q[i].valid && operand_hit(ent_q[i].rdy2, ent_q[i].q2, cdb_valid_in, cdb_tag_w)) begin
                woken[i].v2   = cdb_value_in;
                woken[i].rdy2 = 1'b1;
            end
        end
    end

    rs_oldest_ready_select #(
        .NUM_ENTRIES(NUM_ENTRIES)
    ) u_select (
        .ready(ready_vec),
        .index(sel_idx),
        .found(sel_found)
    );

    assign out_load       = sel_found && (!iss_valid_q || iss_ready_in);
    assign disp_ready_out = (count_q < CNT_W'(NUM_ENTRIES));
    assign disp_fire      = disp_valid_in && disp_ready_out;
    assign count_after    = count_q - CNT_W'(out_load);
    assign count_d        = count_after + CNT_W'(disp_fire);

    // Incoming op, including a same-cycle CDB bypass. Dbr relies on the
    // dispatcher marking both operands ready.
    always_comb begin
        new_ent       = '0;
        new_ent.valid = 1'b1;
        new_ent.func  = br_func_t'(disp_func_in);
        new_ent.v1    = disp_v1_in;
        new_ent.v2    = disp_v2_in;
        new_ent.rdy1  = disp_rdy1_in;
        new_ent.rdy2  = disp_rdy2_in;
        new_ent.q1    = disp_q1_w;
        new_ent.q2    = disp_q2_w;
        new_ent.pc    = disp_pc_in;
        new_ent.imm   = disp_imm_in;
        new_ent.tag   = MAX_TAG_W'(disp_tag_in);
        if (operand_hit(disp_rdy1_in, disp_q1_w, cdb_valid_in, cdb_tag_w)) begin
            new_ent.v1   = cdb_value_in;
            new_ent.rdy1 = 1'b1;
        end
        if (operand_hit(disp_rdy2_in, disp_q2_w, cdb_valid_in, cdb_tag_w)) begin
            new_ent.v2   = cdb_value_in;
            new_ent.rdy2 = 1'b1;
        end
    end

    // Collapse out the issued entry, then append the dispatch behind the
    // survivors so it is always the youngest.
    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            ent_d[i] = woken[i];
        end
        if (out_load) begin
            for (int i = 0; i < NUM_ENTRIES - 1; i++) begin
                if (i >= int'(sel_idx)) begin
                    ent_d[i] = woken[i+1];
                end
            end
            ent_d[NUM_ENTRIES-1] = '0;
        end
        if (disp_fire) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (i == int'(count_after)) begin
                    ent_d[i] = new_ent;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                ent_q[i] <= '0;
            end
            count_q     <= '0;
            iss_valid_q <= 1'b0;
            iss_func_q  <= '0;
            iss_rval1_q <= '0;
            iss_rval2_q <= '0;
            iss_pc_q    <= '0;
            iss_imm_q   <= '0;
            iss_tag_q   <= '0;
        end else if (flush_in) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                ent_q[i].valid <= 1'b0;
            end
            count_q     <= '0;
            iss_valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                ent_q[i] <= ent_d[i];
            end
            count_q <= count_d;
            if (out_load) begin
                iss_valid_q <= 1'b1;
                iss_func_q  <= ent_q[sel_idx].func;
                iss_rval1_q <= ent_q[sel_idx].v1;
                iss_rval2_q <= ent_q[sel_idx].v2;
                iss_pc_q    <= ent_q[sel_idx].pc;
                iss_imm_q   <= ent_q[sel_idx].imm;
                iss_tag_q   <= ent_q[sel_idx].tag[TAG_W-1:0];
            end else if (iss_ready_in) begin
                iss_valid_q <= 1'b0;
            end
        end
    end

    assign iss_valid_out = iss_valid_q;
    assign iss_func_out  = iss_func_q;
    assign iss_rval1_out = iss_rval1_q;
    assign iss_rval2_out = iss_rval2_q;
    assign iss_pc_out    = iss_pc_q;
    assign iss_imm_out   = iss_imm_q;
    assign iss_tag_out   = iss_tag_q;
    assign count_out     = count_q;

endmodule

// File: tb/tb_branch_rs.sv
// Directed bench for branch_rs: expected issues are queued when the stimulus
// makes an op issuable and popped when the issue register presents it.
module tb_branch_rs;
    import branch_rs_pkg::*;

    localparam int NE = 4;
    localparam int RI = 2;

    logic        clk_in = 1'b0;
    logic        rst_in, flush_in;
    logic        disp_valid_in, disp_ready_out;
    logic [2:0]  disp_func_in;
    logic [31:0] disp_v1_in, disp_v2_in, disp_pc_in, disp_imm_in;
    logic        disp_rdy1_in, disp_rdy2_in;
    logic [RI:0] disp_q1_in, disp_q2_in, disp_tag_in;
    logic        cdb_valid_in;
    logic [RI:0] cdb_tag_in;
    logic [31:0] cdb_value_in;
    logic        iss_valid_out, iss_ready_in;
    logic [2:0]  iss_func_out;
    logic [31:0] iss_rval1_out, iss_rval2_out, iss_pc_out, iss_imm_out;
    logic [RI:0] iss_tag_out;
    logic [$clog2(NE+1)-1:0] count_out;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]  func;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [2:0]  tag;
    } exp_t;

    exp_t sb[$];

    branch_rs #(.NUM_ENTRIES(NE), .ROB_IX(RI)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in),
        .disp_valid_in(disp_valid_in), .disp_ready_out(disp_ready_out),
        .disp_func_in(disp_func_in), .disp_v1_in(disp_v1_in), .disp_v2_in(disp_v2_in),
        .disp_rdy1_in(disp_rdy1_in), .disp_rdy2_in(disp_rdy2_in),
        .disp_q1_in(disp_q1_in), .disp_q2_in(disp_q2_in),
        .disp_pc_in(disp_pc_in), .disp_imm_in(disp_imm_in), .disp_tag_in(disp_tag_in),
        .cdb_valid_in(cdb_valid_in), .cdb_tag_in(cdb_tag_in), .cdb_value_in(cdb_value_in),
        .iss_valid_out(iss_valid_out), .iss_ready_in(iss_ready_in),
        .iss_func_out(iss_func_out), .iss_rval1_out(iss_rval1_out), .iss_rval2_out(iss_rval2_out),
        .iss_pc_out(iss_pc_out), .iss_imm_out(iss_imm_out), .iss_tag_out(iss_tag_out),
        .count_out(count_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
        end
    endtask

    task automatic compareIssue(input string name, input exp_t e);
        checkOutput({name, ".func"},  32'(iss_func_out),  32'(e.func));
        checkOutput({name, ".rval1"}, iss_rval1_out,      e.r1);
        checkOutput({name, ".rval2"}, iss_rval2_out,      e.r2);
        checkOutput({name, ".pc"},    iss_pc_out,         e.pc);
        checkOutput({name, ".imm"},   iss_imm_out,        e.imm);
        checkOutput({name, ".tag"},   32'(iss_tag_out),   32'(e.tag));
    endtask

    // Presented op must match the scoreboard head; pop it when consume is set.
    task automatic checkIssue(input string name, input bit consume);
        exp_t e;
        checkOutput({name, ".valid"}, 32'(iss_valid_out), 32'd1);
        checks++;
        assert (sb.size() > 0) else begin
            failures++;
            $error("[TB] FAIL %s.scoreboard observed=empty expected=pending_entry", name);
        end
        if (sb.size() > 0) begin
            e = sb[0];
            if (consume) void'(sb.pop_front());
            compareIssue(name, e);
        end
    endtask

    task automatic pushExp(input logic [2:0] func, input logic [31:0] r1, input logic [31:0] r2,
                           input logic [31:0] pc, input logic [31:0] imm, input logic [2:0] tag);
        exp_t e;
        e.func = func; e.r1 = r1; e.r2 = r2; e.pc = pc; e.imm = imm; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input logic [2:0] func,
                                 input logic [31:0] v1, input logic rdy1, input logic [2:0] q1,
                                 input logic [31:0] v2, input logic rdy2, input logic [2:0] q2,
                                 input logic [31:0] pc, input logic [31:0] imm, input logic [2:0] tag);
        disp_valid_in = 1'b1;
        disp_func_in  = func;
        disp_v1_in    = v1;   disp_rdy1_in = rdy1; disp_q1_in = q1;
        disp_v2_in    = v2;   disp_rdy2_in = rdy2; disp_q2_in = q2;
        disp_pc_in    = pc;   disp_imm_in  = imm;  disp_tag_in = tag;
    endtask

    task automatic idle();
        disp_valid_in = 1'b0;
    endtask

    task automatic cdb(input logic valid, input logic [2:0] tag, input logic [31:0] value);
        cdb_valid_in = valid;
        cdb_tag_in   = tag;
        cdb_value_in = value;
    endtask

    // Fills the issue register (held by backpressure) plus three blocked entries.
    task automatic fillThree();
        iss_ready_in = 1'b0;
        applyStimulus(BR_GE, 32'h11, 1, 0, 32'h22, 1, 0, 32'h800, 32'h30, 3'd4);
        pushExp(BR_GE, 32'h11, 32'h22, 32'h800, 32'h30, 3'd4);
        tick();
        applyStimulus(BR_LT, 0, 0, 7, 1, 1, 0, 32'h804, 32'h0, 3'd5);
        tick();
        applyStimulus(BR_LT, 0, 0, 7, 1, 1, 0, 32'h808, 32'h0, 3'd6);
        tick();
        applyStimulus(BR_LT, 0, 0, 7, 1, 1, 0, 32'h80c, 32'h0, 3'd0);
        tick();
        idle();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_in = 1'b0; flush_in = 1'b0; iss_ready_in = 1'b1;
        disp_valid_in = 1'b0; disp_func_in = '0; disp_v1_in = '0; disp_v2_in = '0;
        disp_rdy1_in = 1'b0; disp_rdy2_in = 1'b0; disp_q1_in = '0; disp_q2_in = '0;
        disp_pc_in = '0; disp_imm_in = '0; disp_tag_in = '0;
        cdb(0, 0, 0);
        tick();
        tick();
        checkOutput("reset.valid", 32'(iss_valid_out), 32'd0);
        checkOutput("reset.count", 32'(count_out), 32'd0);
        checkOutput("reset.disp_ready", 32'(disp_ready_out), 32'd1);
        checkOutput("reset.rval1", iss_rval1_out, 32'd0);
        rst_in = 1'b1;

        // Both operands ready: issue one cycle after the dispatch edge.
        applyStimulus(BR_LT, 32'hFFFFFFFB, 1, 0, 32'd3, 1, 0, 32'h100, 32'h40, 3'd2);
        pushExp(BR_LT, 32'hFFFFFFFB, 32'd3, 32'h100, 32'h40, 3'd2);
        tick();
        idle();
        checkOutput("t1.early_valid", 32'(iss_valid_out), 32'd0);
        checkOutput("t1.count", 32'(count_out), 32'd1);
        tick();
        checkIssue("t1", 1);
        checkOutput("t1.count_after", 32'(count_out), 32'd0);
        tick();
        checkOutput("t1.drain", 32'(iss_valid_out), 32'd0);

        // Operand wakeup through the CDB; a foreign tag must not wake it.
        applyStimulus(BR_EQ, 0, 0, 3, 32'd11, 1, 0, 32'h200, 32'h8, 3'd1);
        tick();
        idle();
        tick();
        cdb(1, 2, 32'd99);
        tick();
        cdb(0, 0, 0);
        checkOutput("t2.wrong_tag", 32'(iss_valid_out), 32'd0);
        checkOutput("t2.count", 32'(count_out), 32'd1);
        cdb(1, 3, 32'd7);
        pushExp(BR_EQ, 32'd7, 32'd11, 32'h200, 32'h8, 3'd1);
        tick();
        cdb(0, 0, 0);
        checkOutput("t2.not_yet", 32'(iss_valid_out), 32'd0);
        tick();
        checkIssue("t2", 1);
        tick();

        // Dispatch bypass from a same-cycle broadcast.
        applyStimulus(BR_NEQ, 32'd4, 1, 0, 0, 0, 5, 32'h300, 32'h12, 3'd3);
        cdb(1, 5, 32'd9);
        pushExp(BR_NEQ, 32'd4, 32'd9, 32'h300, 32'h12, 3'd3);
        tick();
        idle();
        cdb(0, 0, 0);
        checkOutput("t3.early_valid", 32'(iss_valid_out), 32'd0);
        tick();
        checkIssue("t3", 1);
        tick();

        // Full station and out-of-order issue among ready entries.
        iss_ready_in = 1'b0;
        applyStimulus(BR_GE, 32'd21, 1, 0, 32'd22, 1, 0, 32'h500, 32'h10, 3'd7);
        pushExp(BR_GE, 32'd21, 32'd22, 32'h500, 32'h10, 3'd7);
        tick();
        applyStimulus(BR_LTU, 0, 0, 6, 32'd30, 1, 0, 32'h600, 32'h20, 3'd0);
        tick();
        applyStimulus(BR_GEU, 32'd31, 1, 0, 32'd32, 1, 0, 32'h604, 32'h24, 3'd1);
        pushExp(BR_GEU, 32'd31, 32'd32, 32'h604, 32'h24, 3'd1);
        tick();
        applyStimulus(BR_EQ, 0, 0, 6, 32'd40, 1, 0, 32'h608, 32'h28, 3'd2);
        tick();
        applyStimulus(BR_NEQ, 32'd41, 1, 0, 32'd42, 1, 0, 32'h60c, 32'h2c, 3'd3);
        pushExp(BR_NEQ, 32'd41, 32'd42, 32'h60c, 32'h2c, 3'd3);
        tick();
        checkOutput("t4.count_full", 32'(count_out), 32'd4);
        checkOutput("t4.disp_ready", 32'(disp_ready_out), 32'd0);
        applyStimulus(BR_LT, 32'd1, 1, 0, 32'd1, 1, 0, 32'h700, 32'h0, 3'd6);
        tick();
        idle();
        checkOutput("t4.ignored_disp", 32'(count_out), 32'd4);
        checkIssue("t4.blocker", 1);
        iss_ready_in = 1'b1;
        tick();
        checkOutput("t4.count3", 32'(count_out), 32'd3);
        checkIssue("t4.first", 1);
        tick();
        checkOutput("t4.count2", 32'(count_out), 32'd2);
        checkIssue("t4.second", 1);
        tick();
        checkOutput("t4.empty_reg", 32'(iss_valid_out), 32'd0);
        checkOutput("t4.count_rest", 32'(count_out), 32'd2);

        // Backpressure: the issued op is held and nothing else is consumed.
        iss_ready_in = 1'b0;
        cdb(1, 6, 32'd50);
        pushExp(BR_LTU, 32'd50, 32'd30, 32'h600, 32'h20, 3'd0);
        pushExp(BR_EQ, 32'd50, 32'd40, 32'h608, 32'h28, 3'd2);
        tick();
        cdb(0, 0, 0);
        checkOutput("t5.wake_no_issue", 32'(iss_valid_out), 32'd0);
        tick();
        for (int k = 0; k < 3; k++) begin
            checkIssue("t5.hold", 0);
            checkOutput("t5.hold_count", 32'(count_out), 32'd1);
            tick();
        end
        checkIssue("t5.tag0", 1);
        iss_ready_in = 1'b1;
        tick();
        checkIssue("t5.tag2", 1);
        checkOutput("t5.count0", 32'(count_out), 32'd0);
        tick();
        checkOutput("t5.drain", 32'(iss_valid_out), 32'd0);

        // Flush discards a same-cycle dispatch and capture.
        fillThree();
        checkOutput("t6.count3", 32'(count_out), 32'd3);
        checkIssue("t6.held", 1);
        flush_in = 1'b1;
        applyStimulus(BR_EQ, 32'd5, 1, 0, 32'd5, 1, 0, 32'h900, 32'h4, 3'd1);
        cdb(1, 7, 32'd77);
        tick();
        flush_in = 1'b0;
        idle();
        cdb(0, 0, 0);
        checkOutput("t6.count", 32'(count_out), 32'd0);
        checkOutput("t6.valid", 32'(iss_valid_out), 32'd0);
        checkOutput("t6.disp_ready", 32'(disp_ready_out), 32'd1);
        iss_ready_in = 1'b1;
        tick();
        checkOutput("t6.still_empty", 32'(iss_valid_out), 32'd0);
        checkOutput("t6.still_count", 32'(count_out), 32'd0);

        // Mid-operation reset also zeros the issue data.
        fillThree();
        checkIssue("t7.held", 1);
        rst_in = 1'b0;
        tick();
        rst_in = 1'b1;
        checkOutput("t7.valid", 32'(iss_valid_out), 32'd0);
        checkOutput("t7.count", 32'(count_out), 32'd0);
        checkOutput("t7.func", 32'(iss_func_out), 32'd0);
        checkOutput("t7.rval1", iss_rval1_out, 32'd0);
        checkOutput("t7.rval2", iss_rval2_out, 32'd0);
        checkOutput("t7.pc", iss_pc_out, 32'd0);
        checkOutput("t7.imm", iss_imm_out, 32'd0);
        checkOutput("t7.tag", 32'(iss_tag_out), 32'd0);
        iss_ready_in = 1'b1;
        tick();
        checkOutput("t7.after_valid", 32'(iss_valid_out), 32'd0);
        checkOutput("t7.after_count", 32'(count_out), 32'd0);

        checkOutput("end.scoreboard", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
